bus_responder: RTL and testbench
================================

// Module: bus_responder
// PURPOSE
//  Bus target for the 65C02 core: answers the CPU's AD/DO/WE cycles, returns read data on DI,
//  and drives RDY. Bytes outside the I/O page go to internal synchronous RAM, mirrored every 2**RAM_AW.
//  Accesses to the I/O page go to a slow external port through a req/ack handshake.
//  RDY stretches the CPU cycle until the port acks or the access times out.
// PARAMETERS
//  RAM_AW   12     RAM address width; RAM holds 2**RAM_AW bytes, indexed by AD[RAM_AW-1:0]
//  IO_PAGE  8'hFE  AD[15:8] value that selects the I/O page
//  TIMEOUT  15     max cycles in REQ without io_ack before abort (1..255)
// PORTS
//  clk       in   1   CPU clock
//  RST       in   1   synchronous, active-high reset
//  AD        in   16  CPU address (combinational from core, valid every cycle)
//  DO        in   8   CPU write data
//  WE        in   1   CPU write enable
//  DI        out  8   read data to CPU, valid in the cycle after the access completes
//  RDY       out  1   0 stalls CPU; CPU holds AD/DO/WE stable while RDY=0
//  io_req    out  1   I/O request, registered
//  io_we     out  1   I/O write, registered, valid with io_req
//  io_addr   out  8   I/O register offset (AD[7:0]), registered
//  io_wdata  out  8   I/O write data, registered
//  io_rdata  in   8   I/O read data, sampled on the io_ack cycle
//  io_ack    in   1   I/O completion, single-cycle pulse
//  bus_err   out  1   sticky: set on I/O timeout, cleared only by RST
// BEHAVIOUR
//  Decode: io_hit = (AD[15:8]==IO_PAGE). All other addresses are RAM.
//  FSM states: IDLE, REQ, DONE.
//   IDLE, !io_hit: RAM access completes this cycle; RDY=1.
//     WE=1: RAM[AD] <= DO at the clk edge. WE=0: ram_q <= RAM[AD] at the clk edge.
//     sel_io <= 0. Back-to-back RAM accesses run every cycle, zero wait states.
//   IDLE, io_hit: RDY=0 combinationally in the same cycle.
//     Latch io_addr=AD[7:0], io_we=WE, io_wdata=DO. io_req <= 1. Clear tmo counter. Next state REQ.
//   REQ: RDY=0; io_req held 1 with stable addr/we/wdata; tmo counter increments each cycle.
//     io_ack=1: io_req <= 0; io_q <= io_rdata if !io_we, else io_q <= io_q. Next state DONE.
//     No ack, counter==TIMEOUT-1: io_req <= 0; io_q <= 8'hFF; bus_err <= 1. Next state DONE.
//     Ack and timeout in the same cycle: the ack wins, bus_err is not set.
//   DONE: RDY=1, CPU consumes the access at this edge. io_hit is ignored (AD still shows the same
//     address). sel_io <= 1. Next state IDLE.
//  DI = sel_io ? io_q : ram_q. Read latency is 1 cycle after the RDY=1 edge in all cases.
//  I/O access cost: 1 (IDLE) + n (REQ, until ack) + 1 (DONE) cycles.
//  io_ack outside REQ is ignored. RAM is never written while RDY=0.
//  Reset (RST=1 at edge): state=IDLE, io_req=0, io_we=0, io_addr=0, io_wdata=0, io_q=8'hFF,
//    ram_q=8'h00, sel_io=0, bus_err=0, tmo counter=0. RAM contents preserved.
//    RDY is forced to 1 while RST=1.
//    Reset during REQ drops io_req on the next cycle; a late ack after reset is ignored.
//  Counter width is ceil(log2(TIMEOUT+1)); no wrap is possible because abort occurs first.
//  RAM mirror: AD=16'h1234 with RAM_AW=12 addresses RAM[12'h234].
// TESTING
//  1 RAM write AD=0010 DO=5A WE=1, then read AD=0010 -> RDY stays 1; DI=5A the cycle after the read.
//  2 Mirror: write 0x1234=A5, read 0x0234 -> DI=A5 (RAM_AW=12).
//  3 I/O read AD=FE07, ack after 3 REQ cycles with io_rdata=3C -> RDY low 4 cycles;
//    io_addr=07, io_we=0; DI=3C the cycle after DONE.
//  4 I/O write AD=FE01 DO=99, ack 1st REQ cycle -> io_we=1, io_wdata=99, io_req high 1 cycle;
//    RAM unchanged; bus_err=0.
//  5 I/O read with no ack -> io_req drops after 15 cycles; DI=FF; bus_err=1, still set after
//    later accesses until RST.
//  6 RST asserted mid-REQ, late io_ack -> io_req=0, state IDLE, RDY=1;
//    the next RAM read returns the correct data.

Source files
------------

// File: rtl/bus_responder.sv
// -----------------------------------------------------------------------------
// bus_responder
//   Bus target for a 65C02-style core. Each CPU cycle it decodes the address.
//   Addresses outside the I/O page go to internal synchronous RAM with zero
//   wait states. The RAM is mirrored every 2**RAM_AW bytes. Accesses to the
//   I/O page go to a slow external port through a registered req/ack
//   handshake. RDY stays low until the port acks or the access times out.
//
// Ports
//   clk       in   1   CPU clock
//   RST       in   1   synchronous, active-high reset
//   AD        in   16  CPU address (held stable while RDY=0)
//   DO        in   8   CPU write data
//   WE        in   1   CPU write enable
//   DI        out  8   read data, valid the cycle after the completing edge
//   RDY       out  1   0 stalls the CPU
//   io_req    out  1   I/O request (registered)
//   io_we     out  1   I/O write flag, valid with io_req
//   io_addr   out  8   I/O register offset
//   io_wdata  out  8   I/O write data
//   io_rdata  in   8   I/O read data, sampled on the io_ack cycle
//   io_ack    in   1   I/O completion pulse, honoured only in REQ
//   bus_err   out  1   sticky I/O timeout flag, cleared only by RST
// -----------------------------------------------------------------------------
module bus_responder #(
   parameter int          RAM_AW  = 12,
   parameter logic [7:0]  IO_PAGE = 8'hFE,
   parameter int          TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        RST,
   input  logic [15:0] AD,
   input  logic [7:0]  DO,
   input  logic        WE,
   output logic [7:0]  DI,
   output logic        RDY,
   output logic        io_req,
   output logic        io_we,
   output logic [7:0]  io_addr,
   output logic [7:0]  io_wdata,
   input  logic [7:0]  io_rdata,
   input  logic        io_ack,
   output logic        bus_err
);

   localparam int              TW       = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DONE} state_t;

   state_t          state_q,    state_d;
   logic            io_req_q,   io_req_d;
   logic            io_we_q,    io_we_d;
   logic [7:0]      io_addr_q,  io_addr_d;
   logic [7:0]      io_wdata_q, io_wdata_d;
   logic [7:0]      io_q,       io_d;
   logic            sel_io_q,   sel_io_d;
   logic            bus_err_q,  bus_err_d;
   logic [TW-1:0]   tmo_q,      tmo_d;

   logic [7:0]      ram_mem [0:(2**RAM_AW)-1];
   logic [7:0]      ram_q;
   logic [RAM_AW-1:0] ram_idx;
   logic            io_hit;
   logic            ram_acc;

   assign io_hit  = (AD[15:8] == IO_PAGE);
   assign ram_idx = AD[RAM_AW-1:0];
   // A RAM access only happens from IDLE. DONE ignores the decode because the
   // CPU still presents the I/O address while it consumes the result.
   assign ram_acc = (state_q == ST_IDLE) && !io_hit && !RST;

   always_comb begin
      state_d    = state_q;
      io_req_d   = io_req_q;
      io_we_d    = io_we_q;
      io_addr_d  = io_addr_q;
      io_wdata_d = io_wdata_q;
      io_d       = io_q;
      sel_io_d   = sel_io_q;
      bus_err_d  = bus_err_q;
      tmo_d      = tmo_q;
      RDY        = 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (io_hit) begin
               RDY        = 1'b0;
               io_addr_d  = AD[7:0];
               io_we_d    = WE;
               io_wdata_d = DO;
               io_req_d   = 1'b1;
               tmo_d      = '0;
               state_d    = ST_REQ;
            end else begin
               sel_io_d = 1'b0;
            end
         end
         ST_REQ: begin
            RDY   = 1'b0;
            tmo_d = tmo_q + TW'(1);
            // The ack is tested first, so a late-but-valid ack beats the abort.
            if (io_ack) begin
               io_req_d = 1'b0;
               if (!io_we_q) io_d = io_rdata;
               state_d  = ST_DONE;
            end else if (tmo_q == TMO_LAST) begin
               io_req_d  = 1'b0;
               io_d      = 8'hFF;
               bus_err_d = 1'b1;
               state_d   = ST_DONE;
            end
         end
         ST_DONE: begin
            sel_io_d = 1'b1;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // The CPU must see RDY=1 throughout reset so that it never stalls.
      if (RST) RDY = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         state_q    <= ST_IDLE;
         io_req_q   <= 1'b0;
         io_we_q    <= 1'b0;
         io_addr_q  <= 8'h00;
         io_wdata_q <= 8'h00;
         io_q       <= 8'hFF;
         sel_io_q   <= 1'b0;
         bus_err_q  <= 1'b0;
         tmo_q      <= '0;
      end else begin
         state_q    <= state_d;
         io_req_q   <= io_req_d;
         io_we_q    <= io_we_d;
         io_addr_q  <= io_addr_d;
         io_wdata_q <= io_wdata_d;
         io_q       <= io_d;
         sel_io_q   <= sel_io_d;
         bus_err_q  <= bus_err_d;
         tmo_q      <= tmo_d;
      end
   end

   // The RAM array has no reset, so its contents survive RST.
   always_ff @(posedge clk) begin
      if (ram_acc && WE) ram_mem[ram_idx] <= DO;
   end

   // Registered read port. It is updated only on RAM read cycles.
   always_ff @(posedge clk) begin
      if (RST)                 ram_q <= 8'h00;
      else if (ram_acc && !WE) ram_q <= ram_mem[ram_idx];
   end

   assign DI       = sel_io_q ? io_q : ram_q;
   assign io_req   = io_req_q;
   assign io_we    = io_we_q;
   assign io_addr  = io_addr_q;
   assign io_wdata = io_wdata_q;
   assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_bus_responder.sv
// -----------------------------------------------------------------------------
// tb_bus_responder
//   Directed bench for bus_responder. Each scenario has its own task with
//   hand-computed expected values. Inputs change 1 ns after the rising edge.
//   Outputs are sampled 1-2 ns after the edge.
// -----------------------------------------------------------------------------
module tb_bus_responder;

   logic        clk = 1'b0;
   logic        RST;
   logic [15:0] AD;
   logic [7:0]  DO;
   logic        WE;
   logic [7:0]  DI;
   logic        RDY;
   logic        io_req;
   logic        io_we;
   logic [7:0]  io_addr;
   logic [7:0]  io_wdata;
   logic [7:0]  io_rdata;
   logic        io_ack;
   logic        bus_err;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   bus_responder #(.RAM_AW(12), .IO_PAGE(8'hFE), .TIMEOUT(15)) dut (
      .clk(clk), .RST(RST), .AD(AD), .DO(DO), .WE(WE), .DI(DI), .RDY(RDY),
      .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
      .io_rdata(io_rdata), .io_ack(io_ack), .bus_err(bus_err)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      RST = 1'b1; AD = 16'hFE00; WE = 1'b0; DO = 8'h00; io_ack = 1'b0; io_rdata = 8'h00;
      #1;
      n_checks++;
      if (RDY !== 1'b1) begin n_fail++; $display("FAIL rst_rdy got=%b exp=1", RDY); end
      tick; tick;
      n_checks++;
      if (io_req !== 1'b0 || io_we !== 1'b0 || io_addr !== 8'h00 || io_wdata !== 8'h00) begin
         n_fail++;
         $display("FAIL rst_io got req=%b we=%b addr=%h wdata=%h exp 0/0/00/00", io_req, io_we, io_addr, io_wdata);
      end
      n_checks++;
      if (DI !== 8'h00 || bus_err !== 1'b0) begin
         n_fail++; $display("FAIL rst_di got DI=%h err=%b exp 00/0", DI, bus_err);
      end
      RST = 1'b0; AD = 16'h0000;
      tick;
      $display("reset: done");
   endtask

   task automatic test_ram;
      AD = 16'h0010; DO = 8'h5A; WE = 1'b1; #1;
      n_checks++;
      if (RDY !== 1'b1) begin n_fail++; $display("FAIL ram_wr_rdy got=%b exp=1", RDY); end
      tick;
      AD = 16'h0010; WE = 1'b0; #1;
      n_checks++;
      if (RDY !== 1'b1) begin n_fail++; $display("FAIL ram_rd_rdy got=%b exp=1", RDY); end
      tick;
      n_checks++;
      if (DI !== 8'h5A) begin n_fail++; $display("FAIL ram_rd_data got=%h exp=5a", DI); end
      $display("ram: wr/rd 0010 DI=%h", DI);
   endtask

   task automatic test_mirror;
      AD = 16'h1234; DO = 8'hA5; WE = 1'b1;
      tick;
      AD = 16'h0234; WE = 1'b0;
      tick;
      n_checks++;
      if (DI !== 8'hA5) begin n_fail++; $display("FAIL mirror got=%h exp=a5", DI); end
      $display("mirror: wr 1234 rd 0234 DI=%h", DI);
   endtask

   task automatic test_io_read;
      int low = 0;
      AD = 16'hFE07; WE = 1'b0; DO = 8'h00; #1;
      if (RDY === 1'b0) low++;
      tick;
      n_checks++;
      if (io_req !== 1'b1 || io_addr !== 8'h07 || io_we !== 1'b0) begin
         n_fail++; $display("FAIL io_rd_req got req=%b addr=%h we=%b exp 1/07/0", io_req, io_addr, io_we);
      end
      for (int k = 1; k <= 3; k++) begin
         io_ack = (k == 3); io_rdata = 8'h3C; #1;
         if (RDY === 1'b0) low++;
         tick;
      end
      io_ack = 1'b1; io_rdata = 8'h55; #1;   // stray ack in DONE must be ignored
      n_checks++;
      if (low != 4) begin n_fail++; $display("FAIL io_rd_stall got=%0d exp=4", low); end
      n_checks++;
      if (RDY !== 1'b1 || io_req !== 1'b0) begin
         n_fail++; $display("FAIL io_rd_done got rdy=%b req=%b exp 1/0", RDY, io_req);
      end
      tick;
      io_ack = 1'b0; AD = 16'h0000; #1;
      n_checks++;
      if (DI !== 8'h3C) begin n_fail++; $display("FAIL io_rd_data got=%h exp=3c", DI); end
      $display("io_read: FE07 stall=%0d DI=%h", low, DI);
      tick;
   endtask

   task automatic test_io_write;
      int hi = 0;
      AD = 16'h0E01; DO = 8'h77; WE = 1'b1;
      tick;
      AD = 16'hFE01; DO = 8'h99; WE = 1'b1;
      tick;
      n_checks++;
      if (io_we !== 1'b1 || io_wdata !== 8'h99 || io_addr !== 8'h01) begin
         n_fail++; $display("FAIL io_wr_fields got we=%b wdata=%h addr=%h exp 1/99/01", io_we, io_wdata, io_addr);
      end
      if (io_req === 1'b1) hi++;
      io_ack = 1'b1; io_rdata = 8'hEE;
      tick;
      io_ack = 1'b0;
      if (io_req === 1'b1) hi++;
      n_checks++;
      if (hi != 1) begin n_fail++; $display("FAIL io_wr_req_len got=%0d exp=1", hi); end
      tick;
      AD = 16'h0E01; WE = 1'b0; #1;
      n_checks++;
      if (DI !== 8'h3C) begin n_fail++; $display("FAIL io_wr_ioq got=%h exp=3c", DI); end
      tick;
      n_checks++;
      if (DI !== 8'h77) begin n_fail++; $display("FAIL io_wr_ram got=%h exp=77", DI); end
      n_checks++;
      if (bus_err !== 1'b0) begin n_fail++; $display("FAIL io_wr_err got=%b exp=0", bus_err); end
      $display("io_write: FE01=99 ram0E01=%h err=%b", DI, bus_err);
   endtask

   task automatic test_ack_at_timeout;
      AD = 16'hFE30; WE = 1'b0;
      tick;
      for (int k = 1; k <= 15; k++) begin
         io_ack = (k == 15); io_rdata = 8'h42;
         tick;
      end
      io_ack = 1'b0;
      tick;
      AD = 16'h0000; #1;
      n_checks++;
      if (DI !== 8'h42 || bus_err !== 1'b0) begin
         n_fail++; $display("FAIL ack_at_tmo got DI=%h err=%b exp 42/0", DI, bus_err);
      end
      $display("ack_at_timeout: DI=%h err=%b", DI, bus_err);
      tick;
   endtask

   task automatic test_timeout;
      int n = 0;
      AD = 16'hFE10; WE = 1'b0; io_ack = 1'b0;
      tick;
      while (io_req === 1'b1 && n < 40) begin
         n++;
         tick;
      end
      n_checks++;
      if (n != 15) begin n_fail++; $display("FAIL tmo_len got=%0d exp=15", n); end
      n_checks++;
      if (RDY !== 1'b1 || bus_err !== 1'b1) begin
         n_fail++; $display("FAIL tmo_done got rdy=%b err=%b exp 1/1", RDY, bus_err);
      end
      tick;
      AD = 16'h0010; #1;
      n_checks++;
      if (DI !== 8'hFF) begin n_fail++; $display("FAIL tmo_data got=%h exp=ff", DI); end
      tick; tick;
      n_checks++;
      if (bus_err !== 1'b1 || DI !== 8'h5A) begin
         n_fail++; $display("FAIL tmo_sticky got err=%b DI=%h exp 1/5a", bus_err, DI);
      end
      $display("timeout: req_cycles=%0d err=%b", n, bus_err);
   endtask

   task automatic test_reset_mid_req;
      AD = 16'hFE20; WE = 1'b0;
      tick; tick; tick;
      RST = 1'b1; #1;
      n_checks++;
      if (RDY !== 1'b1) begin n_fail++; $display("FAIL rst_req_rdy got=%b exp=1", RDY); end
      tick;
      n_checks++;
      if (io_req !== 1'b0) begin n_fail++; $display("FAIL rst_req_drop got=%b exp=0", io_req); end
      RST = 1'b0; io_ack = 1'b1; io_rdata = 8'hC3; AD = 16'h0010; WE = 1'b0; #1;
      n_checks++;
      if (RDY !== 1'b1) begin n_fail++; $display("FAIL rst_req_idle got=%b exp=1", RDY); end
      tick;
      io_ack = 1'b0;
      n_checks++;
      if (DI !== 8'h5A || io_req !== 1'b0 || bus_err !== 1'b0) begin
         n_fail++; $display("FAIL rst_req_after got DI=%h req=%b err=%b exp 5a/0/0", DI, io_req, bus_err);
      end
      $display("reset_mid_req: DI=%h req=%b err=%b", DI, io_req, bus_err);
   endtask

   initial begin
      test_reset;
      test_ram;
      test_mirror;
      test_io_read;
      test_io_write;
      test_ack_at_timeout;
      test_timeout;
      test_reset_mid_req;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
